rr_sel_sequencer: RTL and testbench

RR_SEL_SEQUENCER -- requirements
Module: rr_sel_sequencer

---
 rtl/rr_sel_sequencer.sv | 82 ++++++++
 tb/tb_rr_sel_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_sequencer.sv
// Four-channel round-robin sequencer: each channel parks one word in a holding
// register, and a registered output stage drains them in rotating priority order.
module rr_sel_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_valid,
  input  logic [3:0] in_data_a,
  input  logic [3:0] in_data_b,
  input  logic [3:0] in_data_c,
  input  logic [3:0] in_data_d,
  output logic [3:0] in_ready,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready
);

  logic [3:0] hold_v;
  logic [3:0] hold_d [4];
  logic [3:0] in_data [4];
  logic [1:0] last_grant;
  logic       out_free;
  logic       grant_en;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  assign in_data[0] = in_data_a;
  assign in_data[1] = in_data_b;
  assign in_data[2] = in_data_c;
  assign in_data[3] = in_data_d;

  // Ready depends on holding state only, so upstream never sees a path from out_ready.
  assign in_ready = ~hold_v;
  assign out_free = !out_valid || out_ready;

  // Search starts one past the last winner; offset 4 wraps back to last_grant itself.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    grant_en  = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_en && hold_v[cand]) begin
        grant_en  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v     <= '0;
      last_grant <= 2'd3;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sel        <= '0;
      // NOTE: the holding data is a handful of flops, not a RAM, so clearing it is cheap and keeps sim X-free.
      for (int i = 0; i < 4; i++) hold_d[i] <= '0;
    end else begin
      // NOTE: non-blocking updates mean the grant below sees pre-edge hold_v, so a word accepted now cannot bypass.
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          hold_v[i] <= 1'b1;
          hold_d[i] <= in_data[i];
        end
      end
      if (out_free) begin
        if (grant_en) begin
          out_data          <= hold_d[grant_idx];
          sel               <= grant_idx;
          out_valid         <= 1'b1;
          hold_v[grant_idx] <= 1'b0;
          last_grant        <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Bench for rr_sel_sequencer: queue-based reference model compared every cycle,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_rr_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_data_a, in_data_b, in_data_c, in_data_d;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_sel_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_a (in_data_a),
    .in_data_b (in_data_b),
    .in_data_c (in_data_c),
    .in_data_d (in_data_d),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: each channel owns a queue of at most one pending word.
  logic [3:0] m_pend [4][$];
  int         m_last;
  logic       m_ov;
  int         m_sel;
  logic [3:0] m_od;

  function automatic logic [3:0] chan_data(int i);
    case (i)
      0: return in_data_a;
      1: return in_data_b;
      2: return in_data_c;
      default: return in_data_d;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_pend[i].delete();
      m_last = 3;
      m_ov   = 1'b0;
      m_sel  = 0;
      m_od   = 4'h0;
    end else begin
      int  g;
      bit  free;
      logic [3:0] acc_d [4];
      bit  acc [4];
      free = !m_ov || out_ready;
      g = -1;
      if (free)
        for (int k = 1; k <= 4; k++)
          if (g < 0 && m_pend[(m_last + k) % 4].size() != 0) g = (m_last + k) % 4;
      for (int i = 0; i < 4; i++) begin
        acc[i]   = in_valid[i] && (m_pend[i].size() == 0);
        acc_d[i] = chan_data(i);
      end
      if (g >= 0) begin
        m_od   = m_pend[g].pop_front();
        m_sel  = g;
        m_ov   = 1'b1;
        m_last = g;
      end else if (free) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if (acc[i]) m_pend[i].push_back(acc_d[i]);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] m_rdy;
    for (int i = 0; i < 4; i++) m_rdy[i] = (m_pend[i].size() == 0);
    check("model_out_valid", 8'(out_valid), 8'(m_ov));
    check("model_in_ready", 8'(in_ready), 8'(m_rdy));
    check("model_sel", 8'(sel), 8'(m_sel));
    check("model_out_data", 8'(out_data), 8'(m_od));
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_data(input logic [3:0] a, b, c, d);
    in_data_a = a; in_data_b = b; in_data_c = c; in_data_d = d;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    set_data(4'h0, 4'h0, 4'h0, 4'h0);
    #2;
    check("reset_out_valid", 8'(out_valid), 8'h0);
    check("reset_in_ready", 8'(in_ready), 8'hF);
    tick();
    rst_n = 1'b1;

    // Single word on channel c.
    in_valid = 4'b0100; set_data(4'h0, 4'h0, 4'hA, 4'h0);
    tick();
    in_valid = '0;
    tick();
    check("single_valid", 8'(out_valid), 8'h1);
    check("single_sel", 8'(sel), 8'h2);
    check("single_data", 8'(out_data), 8'hA);
    tick();
    check("single_drain", 8'(out_valid), 8'h0);

    // Round robin from reset.
    do_reset();
    in_valid = 4'b1111; set_data(4'h1, 4'h2, 4'h3, 4'h4);
    tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_sel", 8'(sel), 8'(i));
      check("rr_data", 8'(out_data), 8'(i + 1));
    end

    // Backpressure with a and b pending.
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0011; set_data(4'h5, 4'h6, 4'h0, 4'h0);
    tick();
    in_valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_sel", 8'(sel), 8'h0);
      check("bp_data", 8'(out_data), 8'h5);
      check("bp_ready_b", 8'(in_ready[1]), 8'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_sel", 8'(sel), 8'h1);
    check("bp_release_data", 8'(out_data), 8'h6);

    // Asynchronous reset while a word is on the output.
    check("pre_reset_valid", 8'(out_valid), 8'h1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 8'(out_valid), 8'h0);
    check("async_sel", 8'(sel), 8'h0);
    check("async_out_data", 8'(out_data), 8'h0);
    check("async_in_ready", 8'(in_ready), 8'hF);
    tick();
    rst_n = 1'b1;

    // Fairness wrap: last grant d, then a and d pending.
    in_valid = 4'b1000; set_data(4'h0, 4'h0, 4'h0, 4'h7);
    tick();
    out_ready = 1'b0;
    in_valid = '0;
    tick();
    in_valid = 4'b1001; set_data(4'h8, 4'h0, 4'h0, 4'h9);
    tick();
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    check("wrap_first_sel", 8'(sel), 8'h0);
    check("wrap_first_data", 8'(out_data), 8'h8);
    tick();
    check("wrap_second_sel", 8'(sel), 8'h3);
    check("wrap_second_data", 8'(out_data), 8'h9);

    // Overrun: a stays valid with changing data while its word is held.
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b1000; set_data(4'h0, 4'h0, 4'h0, 4'h1);
    tick();
    in_valid = '0;
    tick();
    in_valid = 4'b0001; in_data_a = 4'h2;
    tick();
    for (int i = 3; i < 6; i++) begin
      in_data_a = 4'(i);
      tick();
      check("overrun_ready_a", 8'(in_ready[0]), 8'h0);
    end
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    check("overrun_sel", 8'(sel), 8'h0);
    check("overrun_data", 8'(out_data), 8'h2);

    // Randomized traffic with occasional mid-operation resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = 4'($urandom);
      set_data(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
      rst_n = 1'b1;
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
